// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus widths and arbiter state encodings.
package mem_bus_arbiter_pkg;

    localparam int unsigned BusAddrWidth = 32;
    localparam int unsigned BusDataWidth = 32;
    localparam int unsigned BusSelWidth  = 4;

    typedef enum logic [1:0] {
        ArbIdle     = 2'd0,
        ArbIbusy    = 2'd1,
        ArbDbusy    = 2'd2,
        ArbIdiscard = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_bus_port_buf.sv
// Per-port completion buffer: done flag, captured read data and the port's stall term.
module mem_bus_port_buf
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BusDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  complete,
    input  logic                  drop,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  pending
);

    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // A finished result is held until the pipeline actually advances.
    always_comb begin
        done_d  = done_q;
        rdata_d = rdata_q;
        if (drop) begin
            done_d = 1'b0;
        end else if (complete) begin
            done_d  = 1'b1;
            rdata_d = bus_rdata;
        end else if (advance) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign valid   = done_q;
    assign pending = req & ~done_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports, data first, one transaction at a time.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BusAddrWidth,
    parameter int unsigned DATA_WIDTH = BusDataWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_req,
    input  logic [ADDR_WIDTH-1:0]  inst_addr,
    output logic [DATA_WIDTH-1:0]  inst_rdata,
    output logic                   inst_valid,
    input  logic                   data_req,
    input  logic                   data_we,
    input  logic [BusSelWidth-1:0] data_sel,
    input  logic [ADDR_WIDTH-1:0]  data_addr,
    input  logic [DATA_WIDTH-1:0]  data_wdata,
    output logic [DATA_WIDTH-1:0]  data_rdata,
    output logic                   data_valid,
    input  logic                   flush,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [BusSelWidth-1:0] bus_sel,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [DATA_WIDTH-1:0]  bus_wdata,
    input  logic [DATA_WIDTH-1:0]  bus_rdata,
    input  logic                   bus_ready,
    output logic                   stall_all
);

    arb_state_e             state_q, state_d;
    logic                   bus_req_q, bus_req_d;
    logic                   bus_we_q, bus_we_d;
    logic [BusSelWidth-1:0] bus_sel_q, bus_sel_d;
    logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]  bus_wdata_q, bus_wdata_d;

    logic inst_pending, data_pending;
    logic inst_complete, data_complete;

    assign stall_all = inst_pending | data_pending | (state_q == ArbIdiscard);

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_sel_d     = bus_sel_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        inst_complete = 1'b0;
        data_complete = 1'b0;
        case (state_q)
            ArbIdle: begin
                if (data_pending) begin
                    state_d     = ArbDbusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = data_we;
                    bus_sel_d   = data_sel;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (inst_pending) begin
                    state_d     = ArbIbusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = '1;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                end
            end
            ArbIbusy: begin
                if (bus_ready) begin
                    state_d       = ArbIdle;
                    bus_req_d     = 1'b0;
                    inst_complete = ~flush;
                end else if (flush) begin
                    // Keep the bus cycle alive but throw its result away.
                    state_d = ArbIdiscard;
                end
            end
            ArbDbusy: begin
                if (bus_ready) begin
                    state_d       = ArbIdle;
                    bus_req_d     = 1'b0;
                    data_complete = 1'b1;
                end
            end
            ArbIdiscard: begin
                if (bus_ready) begin
                    state_d   = ArbIdle;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ArbIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ArbIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    mem_bus_port_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (inst_req),
        .complete  (inst_complete),
        .drop      (flush),
        .advance   (~stall_all),
        .bus_rdata (bus_rdata),
        .rdata     (inst_rdata),
        .valid     (inst_valid),
        .pending   (inst_pending)
    );

    // Data transactions are never aborted, so flush does not reach this port.
    mem_bus_port_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (data_req),
        .complete  (data_complete),
        .drop      (1'b0),
        .advance   (~stall_all),
        .bus_rdata (bus_rdata),
        .rdata     (data_rdata),
        .valid     (data_valid),
        .pending   (data_pending)
    );

endmodule
